// File: rtl/stream_downsizer.sv
// Width downsizer: accepts one DW_OUT*SCALE-bit word and replays it as SCALE
// narrow beats, with zero-bubble reload when the final beat is consumed.
module stream_downsizer #(
    parameter int unsigned DW_OUT    = 8,
    parameter int unsigned SCALE     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW_OUT*SCALE-1:0]  s_data_i,
    input  logic                     s_valid_i,
    input  logic                     s_last_i,
    output logic                     s_ready_o,
    output logic [DW_OUT-1:0]        m_data_o,
    output logic                     m_valid_o,
    output logic                     m_last_o,
    input  logic                     m_ready_i
);

    localparam int unsigned IDXW = (SCALE > 2) ? $clog2(SCALE) : 1;
    localparam int unsigned DW_IN = DW_OUT * SCALE;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SCALE - 1);

    logic              full_q, full_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              last_q, last_d;
    logic [DW_IN-1:0]  data_q;
    logic [IDXW-1:0]   sel;
    logic              wr, rd, wrap;

    assign wrap      = (idx_q == LAST_IDX);
    assign rd        = full_q & m_ready_i;
    // Ready is gated by rst_n so it stays low for the whole reset window.
    assign s_ready_o = rst_n & (~full_q | (rd & wrap));
    assign wr        = s_valid_i & s_ready_o;
    assign m_valid_o = full_q;
    assign m_last_o  = full_q & last_q & wrap;
    assign sel       = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;

    always_comb begin
        m_data_o = '0;
        for (int unsigned i = 0; i < SCALE; i++) begin
            if (sel == IDXW'(i)) begin
                m_data_o = data_q[i*DW_OUT +: DW_OUT];
            end
        end
    end

    // A load wins over the wrap-clear so the final beat can hand straight over.
    always_comb begin
        full_d = full_q;
        idx_d  = idx_q;
        last_d = last_q;
        if (wr) begin
            full_d = 1'b1;
            idx_d  = '0;
            last_d = s_last_i;
        end else if (rd) begin
            if (wrap) begin
                full_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            data_q <= s_data_i;
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// Bench for stream_downsizer: directed scenarios plus randomized traffic
// checked against a queue-of-beats reference model.
module tb_stream_downsizer;

    localparam int DW_OUT = 8;
    localparam int SCALE  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        s_ready_a, m_valid_a, m_last_a;
    logic [7:0]  m_data_a;
    logic        s_ready_b, m_valid_b, m_last_b;
    logic [7:0]  m_data_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] lsb;
        logic [7:0] msb;
        logic       last;
    } beat_t;

    beat_t q[$];

    always #5 clk = ~clk;

    stream_downsizer #(.DW_OUT(DW_OUT), .SCALE(SCALE), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
        .s_ready_o(s_ready_a), .m_data_o(m_data_a), .m_valid_o(m_valid_a), .m_last_o(m_last_a),
        .m_ready_i(m_ready)
    );

    stream_downsizer #(.DW_OUT(DW_OUT), .SCALE(SCALE), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
        .s_ready_o(s_ready_b), .m_data_o(m_data_b), .m_valid_o(m_valid_b), .m_last_o(m_last_b),
        .m_ready_i(m_ready)
    );

    // Model: a word is space for SCALE beats; input is accepted when the queue
    // is empty or its last beat is leaving this cycle.
    function automatic logic exp_ready();
        return rst_n && (q.size() == 0 || (q.size() == 1 && m_ready));
    endfunction

    function automatic logic exp_valid();
        return q.size() != 0;
    endfunction

    task automatic push_word(input logic [31:0] d, input logic l);
        beat_t b;
        for (int i = 0; i < SCALE; i++) begin
            b.lsb  = d[i*8 +: 8];
            b.msb  = d[(SCALE-1-i)*8 +: 8];
            b.last = l && (i == SCALE - 1);
            q.push_back(b);
        end
    endtask

    task automatic tick();
        logic wr, rd;
        wr = s_valid && exp_ready();
        rd = exp_valid() && m_ready && rst_n;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (rd) void'(q.pop_front());
            if (wr) push_word(s_data, s_last);
        end
    endtask

    task automatic test_reset();
        s_valid = 1'b0; m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        n_cmp++; if (s_ready_a !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", s_ready_a); end
        n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", m_valid_a); end
        n_cmp++; if (m_last_a !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b expected 0", m_last_a); end
        s_valid = 1'b1; m_ready = 1'b1; s_data = $urandom;
        tick(); tick();
        #2;
        n_cmp++; if (s_ready_a !== 1'b0) begin n_err++; $display("FAIL rst_ready_held: got %b expected 0", s_ready_a); end
        n_cmp++; if (m_valid_b !== 1'b0) begin n_err++; $display("FAIL rst_valid_b: got %b expected 0", m_valid_b); end
        rst_n = 1'b1; s_valid = 1'b0;
        #2;
        n_cmp++; if (s_ready_a !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b expected 1", s_ready_a); end
        n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b expected 0", m_valid_a); end
        tick();
    endtask

    task automatic test_single_word();
        logic [7:0] bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        s_data = 32'hDDCCBBAA; s_last = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        #2;
        n_cmp++; if (s_ready_a !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b expected 1", s_ready_a); end
        tick();
        s_valid = 1'b0; s_data = $urandom;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %b expected 1", i, m_valid_a); end
            n_cmp++; if (m_data_a !== bytes[i]) begin n_err++; $display("FAIL single_data[%0d]: got %h expected %h", i, m_data_a, bytes[i]); end
            n_cmp++; if (m_data_b !== bytes[3-i]) begin n_err++; $display("FAIL msb_first_data[%0d]: got %h expected %h", i, m_data_b, bytes[3-i]); end
            n_cmp++; if (s_ready_a !== (i == 3)) begin n_err++; $display("FAIL single_ready[%0d]: got %b expected %b", i, s_ready_a, (i == 3)); end
            tick();
        end
        #2;
        n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b expected 0", m_valid_a); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        s_data = 32'h44332211; s_last = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        #2;
        tick();
        s_data = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            e = 8'((i + 1) * 17);
            #2;
            n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, m_valid_a); end
            n_cmp++; if (m_data_a !== e) begin n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, m_data_a, e); end
            tick();
            if (i == 3) s_valid = 1'b0;
        end
        #2;
        n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b expected 0", m_valid_a); end
        tick();
    endtask

    task automatic test_stall();
        s_data = 32'hDDCCBBAA; s_last = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        #2;
        tick();
        s_valid = 1'b0;
        #2;
        n_cmp++; if (m_data_a !== 8'hAA) begin n_err++; $display("FAIL stall_first: got %h expected aa", m_data_a); end
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++; if (m_data_a !== 8'hBB) begin n_err++; $display("FAIL stall_hold_data[%0d]: got %h expected bb", i, m_data_a); end
            n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("FAIL stall_hold_valid[%0d]: got %b expected 1", i, m_valid_a); end
            tick();
        end
        m_ready = 1'b1;
        #2;
        n_cmp++; if (m_data_a !== 8'hBB) begin n_err++; $display("FAIL stall_release: got %h expected bb", m_data_a); end
        tick();
        #2;
        n_cmp++; if (m_data_a !== 8'hCC) begin n_err++; $display("FAIL stall_next: got %h expected cc", m_data_a); end
        tick();
        #2;
        n_cmp++; if (m_data_a !== 8'hDD) begin n_err++; $display("FAIL stall_final: got %h expected dd", m_data_a); end
        tick();
    endtask

    task automatic test_last();
        s_data = 32'hDDCCBBAA; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        #2;
        tick();
        s_data = $urandom; s_last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #2;
            n_cmp++; if (m_last_a !== (i == 3)) begin n_err++; $display("FAIL last_flag[%0d]: got %b expected %b", i, m_last_a, (i == 3)); end
            n_cmp++; if (m_last_b !== (i == 3)) begin n_err++; $display("FAIL last_flag_b[%0d]: got %b expected %b", i, m_last_b, (i == 3)); end
            tick();
            if (i == 3) s_valid = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        s_data = 32'hDDCCBBAA; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        #2;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", m_valid_a); end
        n_cmp++; if (s_ready_a !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b expected 0", s_ready_a); end
        n_cmp++; if (m_last_a !== 1'b0) begin n_err++; $display("FAIL midrst_last: got %b expected 0", m_last_a); end
        rst_n = 1'b1;
        q.delete();
        s_data = 32'h04030201; s_last = 1'b0; s_valid = 1'b1;
        #1;
        n_cmp++; if (s_ready_a !== 1'b1) begin n_err++; $display("FAIL midrst_reaccept: got %b expected 1", s_ready_a); end
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++; if (m_data_a !== 8'(i + 1)) begin n_err++; $display("FAIL midrst_data[%0d]: got %h expected %h", i, m_data_a, 8'(i + 1)); end
            n_cmp++; if (m_data_b !== 8'(4 - i)) begin n_err++; $display("FAIL midrst_data_b[%0d]: got %h expected %h", i, m_data_b, 8'(4 - i)); end
            tick();
        end
    endtask

    task automatic test_random();
        logic er, ev;
        for (int n = 0; n < 400; n++) begin
            s_valid = ($urandom_range(3) != 0);
            s_data  = $urandom;
            s_last  = 1'($urandom_range(1));
            m_ready = ($urandom_range(3) != 0);
            #2;
            er = exp_ready();
            ev = exp_valid();
            n_cmp++; if (s_ready_a !== er) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, s_ready_a, er); end
            n_cmp++; if (s_ready_b !== er) begin n_err++; $display("FAIL rnd_ready_b[%0d]: got %b expected %b", n, s_ready_b, er); end
            n_cmp++; if (m_valid_a !== ev) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, m_valid_a, ev); end
            if (ev) begin
                n_cmp++; if (m_data_a !== q[0].lsb) begin n_err++; $display("FAIL rnd_data[%0d]: got %h expected %h", n, m_data_a, q[0].lsb); end
                n_cmp++; if (m_data_b !== q[0].msb) begin n_err++; $display("FAIL rnd_data_b[%0d]: got %h expected %h", n, m_data_b, q[0].msb); end
                n_cmp++; if (m_last_a !== q[0].last) begin n_err++; $display("FAIL rnd_last[%0d]: got %b expected %b", n, m_last_a, q[0].last); end
            end else begin
                n_cmp++; if (m_last_a !== 1'b0) begin n_err++; $display("FAIL rnd_last_idle[%0d]: got %b expected 0", n, m_last_a); end
            end
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (8) tick();
        #2;
        n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL rnd_drained: got %b expected 0", m_valid_a); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_last();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_downsizer.md
STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 SHALL have parameter DW_OUT, default 8, giving the width in bits of one output (narrow) beat.
REQ-002 SHALL have parameter SCALE, default 4, giving the number of narrow beats per input word (SCALE >= 2).
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = least-significant slice first, 1 = most-significant slice first.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port s_data_i, input, DW_OUT*SCALE bits: wide input word.
REQ-007 SHALL have port s_valid_i, input, 1 bit: input word valid.
REQ-008 SHALL have port s_last_i, input, 1 bit: input word ends a packet.
REQ-009 SHALL have port s_ready_o, output, 1 bit: the block can accept an input word this cycle.
REQ-010 SHALL have port m_data_o, output, DW_OUT bits: narrow output beat.
REQ-011 SHALL have port m_valid_o, output, 1 bit: output beat valid.
REQ-012 SHALL have port m_last_o, output, 1 bit: final beat of a packet.
REQ-013 SHALL have port m_ready_i, input, 1 bit: the downstream consumer accepts the current beat.

Function
REQ-014 SHALL hold state: full flag, beat index idx (width clog2(SCALE), minimum 1), DW_OUT*SCALE data register, 1-bit last register.
REQ-015 SHALL define wr = s_valid_i & s_ready_o, rd = m_valid_o & m_ready_i, and wrap = (idx == SCALE-1).
REQ-016 SHALL drive m_valid_o = full.
REQ-017 SHALL drive m_data_o = data slice idx (bits idx*DW_OUT upward) when MSB_FIRST=0, and slice SCALE-1-idx when MSB_FIRST=1.
REQ-018 SHALL drive m_last_o = full & last register & wrap, so it is never asserted on a non-final beat.
REQ-019 SHALL drive s_ready_o = !full | (rd & wrap), a combinational path from m_ready_i, giving zero-bubble reload.
REQ-020 SHALL, on wr, load the data register from s_data_i, load the last register from s_last_i, set idx to 0 and set full to 1.
REQ-021 SHALL, on rd without wrap, increment idx and leave full and data unchanged.
REQ-022 SHALL, on rd with wrap and no wr, clear full and set idx to 0.
REQ-023 SHALL, on rd with wrap and wr in the same cycle, give the load of REQ-020 priority so that full stays 1.
REQ-024 SHALL hold m_data_o, m_last_o and idx stable while m_valid_o=1 and m_ready_i=0 (AXI-style stall).
REQ-025 SHALL sustain one narrow beat per cycle with continuous s_valid_i and m_ready_i, with no idle cycle between words.
REQ-026 SHALL have a latency of one cycle from wr to the first beat at m_valid_o.
REQ-027 SHALL ignore s_data_i and s_last_i when wr=0.

Reset
REQ-028 SHALL, while rst_n=0 and independent of clk, clear full, idx and the last register.
REQ-029 SHALL, while rst_n=0, force s_ready_o=0, m_valid_o=0 and m_last_o=0.
REQ-030 SHALL leave the data register unreset; its contents are don't-care while full=0.
REQ-031 SHALL, on reset asserted mid-word, discard the partially sent word; after release the next accepted word starts at idx 0.
REQ-032 SHALL drive s_ready_o=1 in the first cycle after rst_n rises.

Verification
REQ-033 SHALL check, with DW_OUT=8, SCALE=4, m_ready_i=1: word 0xDDCCBBAA -> beats AA, BB, CC, DD on 4 consecutive cycles; s_ready_o=0 on beats AA-CC and 1 on beat DD.
REQ-034 SHALL check back-to-back words 0x44332211 then 0x88776655 with m_ready_i=1 -> beats 11..88 on 8 consecutive cycles with no gap.
REQ-035 SHALL check stalls: m_ready_i=0 for 3 cycles while beat BB is presented -> m_data_o held at 0xBB and m_valid_o held at 1; CC follows on the cycle after m_ready_i returns.
REQ-036 SHALL check packet end: s_last_i=1 with 0xDDCCBBAA -> m_last_o=1 only with beat DD; a following word sent with s_last_i=0 -> m_last_o=0 on all 4 beats.
REQ-037 SHALL check mid-word reset: rst_n pulsed low after beat BB -> m_valid_o=0 immediately; next word 0x04030201 -> beats 01, 02, 03, 04.
REQ-038 SHALL check MSB_FIRST=1: word 0xDDCCBBAA -> beats DD, CC, BB, AA.
